input_port_cluster_credit: RTL and testbench

Parametrised successor to the per-leaf input port array. Sits between the leaf's BFT receive stream and the user operator inputs. It steers each incoming packet by source (leaf, port) match into one of NUM_IN_PORTS on-chip FIFOs with configurable depth, and presents FIFO heads to the user with a valid/ack handshake. It returns credits to senders as freespace_update pulses every FREESPACE_UPDATE_SIZE consumed words. New in this generation: per-port enable mask, multicast delivery, sticky per-port overflow flags and a saturating drop counter for diagnostics.

---
 rtl/input_port_cluster_credit.sv | 114 +++++++++++
 tb/tb_input_port_cluster_credit.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/input_port_cluster_credit.sv
// Steers BFT packets by source (leaf, port) into per-port FWFT FIFOs, with multicast and credit-return pulses.
// Latency: a packet accepted at edge t is visible on vld2user/dout2user after edge t; a pop shows the next head after its edge.
// Backpressure: no upstream stall; a hit on a full FIFO without a same-cycle pop is dropped, flagged and counted.
module input_port_cluster_credit #(
    parameter int NUM_LEAF_BITS         = 6,
    parameter int NUM_PORT_BITS         = 4,
    parameter int PAYLOAD_BITS          = 64,
    parameter int PACKET_BITS           = 85,
    parameter int NUM_IN_PORTS          = 7,
    parameter int FIFO_ADDR_BITS        = 7,
    parameter int FREESPACE_UPDATE_SIZE = 64,
    parameter int DROP_CNT_BITS         = 16
) (
    input  logic                                              clk,
    input  logic                                              reset,
    input  logic [PACKET_BITS-1:0]                            stream_in,
    input  logic [(NUM_LEAF_BITS+NUM_PORT_BITS)*NUM_IN_PORTS-1:0] in_control_reg,
    input  logic [NUM_IN_PORTS-1:0]                           port_enable,
    output logic [PAYLOAD_BITS*NUM_IN_PORTS-1:0]              dout2user,
    output logic [NUM_IN_PORTS-1:0]                           vld2user,
    input  logic [NUM_IN_PORTS-1:0]                           ack_user2b_in,
    output logic [NUM_IN_PORTS-1:0]                           freespace_update,
    output logic [NUM_IN_PORTS-1:0]                           overflow_flag,
    output logic [DROP_CNT_BITS-1:0]                          drop_count
);

    localparam int SRC_BITS  = NUM_LEAF_BITS + NUM_PORT_BITS;
    localparam int DEPTH     = 1 << FIFO_ADDR_BITS;
    localparam int CONS_BITS = $clog2(FREESPACE_UPDATE_SIZE + 1);

    localparam logic [CONS_BITS-1:0]      CREDIT_WORDS = CONS_BITS'(FREESPACE_UPDATE_SIZE);
    localparam logic [CONS_BITS-1:0]      CONS_ONE     = CONS_BITS'(1);
    localparam logic [FIFO_ADDR_BITS:0]   FULL_CNT     = (FIFO_ADDR_BITS+1)'(DEPTH);
    localparam logic [FIFO_ADDR_BITS:0]   CNT_ONE      = (FIFO_ADDR_BITS+1)'(1);
    localparam logic [FIFO_ADDR_BITS-1:0] PTR_ONE      = FIFO_ADDR_BITS'(1);
    localparam logic [DROP_CNT_BITS-1:0]  DROP_ONE     = DROP_CNT_BITS'(1);

    typedef struct packed {
        logic                     vld;
        logic [NUM_LEAF_BITS-1:0] dst_leaf;
        logic [NUM_PORT_BITS-1:0] dst_port;
        logic [NUM_LEAF_BITS-1:0] src_leaf;
        logic [NUM_PORT_BITS-1:0] src_port;
        logic [PAYLOAD_BITS-1:0]  payload;
    } pkt_t;

    pkt_t                    pkt;
    logic [NUM_IN_PORTS-1:0] push;
    logic                    unused_dst;

    assign pkt        = pkt_t'(stream_in);
    // Destination was already resolved by the BFT; only the source selects a port here.
    assign unused_dst = ^{pkt.dst_leaf, pkt.dst_port};

    for (genvar i = 0; i < NUM_IN_PORTS; i++) begin : g_port
        logic [PAYLOAD_BITS-1:0]   mem [DEPTH];
        logic [FIFO_ADDR_BITS-1:0] wr_ptr;
        logic [FIFO_ADDR_BITS-1:0] rd_ptr;
        logic [FIFO_ADDR_BITS:0]   count;
        logic [CONS_BITS-1:0]      consumed;
        logic                      ovf_q;
        logic                      hit;
        logic                      pop;
        logic                      full;

        assign hit     = pkt.vld & port_enable[i] &
                         ({pkt.src_leaf, pkt.src_port} == in_control_reg[i*SRC_BITS +: SRC_BITS]);
        assign pop     = (count != '0) & ack_user2b_in[i];
        assign full    = (count == FULL_CNT);
        // A pop in the same cycle frees the slot, so a full FIFO still accepts.
        assign push[i] = hit & (~full | pop);

        always_ff @(posedge clk) begin
            if (push[i]) mem[wr_ptr] <= pkt.payload;
        end

        always_ff @(posedge clk) begin
            if (!reset) begin
                wr_ptr   <= '0;
                rd_ptr   <= '0;
                count    <= '0;
                consumed <= '0;
                ovf_q    <= 1'b0;
            end else begin
                if (push[i]) wr_ptr <= wr_ptr + PTR_ONE;
                if (pop)     rd_ptr <= rd_ptr + PTR_ONE;
                case ({push[i], pop})
                    2'b10:   count <= count + CNT_ONE;
                    2'b01:   count <= count - CNT_ONE;
                    default: count <= count;
                endcase
                // Credit counter parks at the threshold for one cycle to form the pulse.
                if (consumed == CREDIT_WORDS)
                    consumed <= pop ? CONS_ONE : '0;
                else if (pop)
                    consumed <= consumed + CONS_ONE;
                if (hit & full & ~pop) ovf_q <= 1'b1;
            end
        end

        assign vld2user[i]                                 = (count != '0);
        assign dout2user[i*PAYLOAD_BITS +: PAYLOAD_BITS]   = vld2user[i] ? mem[rd_ptr] : '0;
        assign freespace_update[i]                         = (consumed == CREDIT_WORDS);
        assign overflow_flag[i]                            = ovf_q;
    end

    always_ff @(posedge clk) begin
        if (!reset)
            drop_count <= '0;
        else if (pkt.vld && (push == '0) && (drop_count != '1))
            drop_count <= drop_count + DROP_ONE;
    end

endmodule

// File: tb/tb_input_port_cluster_credit.sv
// Scoreboard bench for input_port_cluster_credit: depth 4, credit every 4 words, 2-bit drop counter.
// Expected payloads are queued per port on acceptance and compared when the DUT pops them.
module tb_input_port_cluster_credit;

    localparam int NP    = 7;
    localparam int PL    = 64;
    localparam int DEPTH = 4;
    localparam int FSU   = 4;
    localparam int DMAX  = 3;

    logic             clk = 1'b0;
    logic             reset;
    logic [84:0]      stream_in;
    logic [10*NP-1:0] in_control_reg;
    logic [NP-1:0]    port_enable;
    logic [PL*NP-1:0] dout2user;
    logic [NP-1:0]    vld2user;
    logic [NP-1:0]    ack_user2b_in;
    logic [NP-1:0]    freespace_update;
    logic [NP-1:0]    overflow_flag;
    logic [1:0]       drop_count;

    input_port_cluster_credit #(
        .NUM_LEAF_BITS(6), .NUM_PORT_BITS(4), .PAYLOAD_BITS(64), .PACKET_BITS(85),
        .NUM_IN_PORTS(NP), .FIFO_ADDR_BITS(2), .FREESPACE_UPDATE_SIZE(FSU), .DROP_CNT_BITS(2)
    ) dut (
        .clk(clk), .reset(reset), .stream_in(stream_in), .in_control_reg(in_control_reg),
        .port_enable(port_enable), .dout2user(dout2user), .vld2user(vld2user),
        .ack_user2b_in(ack_user2b_in), .freespace_update(freespace_update),
        .overflow_flag(overflow_flag), .drop_count(drop_count)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    logic [63:0]   sb [NP][$];
    int            cons [NP];
    int            pulse_cnt [NP];
    logic [NP-1:0] ovf_m;
    int            dm;

    logic          cur_vld;
    logic [5:0]    cur_sl;
    logic [3:0]    cur_sp;
    logic [63:0]   cur_pl;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_ctrl(input int i, input logic [5:0] leaf, input logic [3:0] port);
        in_control_reg[i*10 +: 10] = {leaf, port};
    endtask

    // One clock: compare pre-edge outputs and pops against the model, advance the model, check post-edge state.
    task automatic step();
        bit any;
        any = 1'b0;
        #1;
        for (int i = 0; i < NP; i++) begin
            bit          pop;
            bit          hit;
            logic [63:0] exp_pl;
            pop = ack_user2b_in[i] && (sb[i].size() > 0);
            chk($sformatf("vld%0d", i), 64'(vld2user[i]), 64'(sb[i].size() > 0));
            chk($sformatf("credit%0d", i), 64'(freespace_update[i]), 64'(cons[i] == FSU));
            if (freespace_update[i]) pulse_cnt[i]++;
            if (pop) begin
                exp_pl = sb[i].pop_front();
                chk($sformatf("dout%0d", i), dout2user[i*PL +: PL], exp_pl);
            end
            if (cons[i] == FSU) cons[i] = pop ? 1 : 0;
            else if (pop)       cons[i]++;
            hit = cur_vld && port_enable[i] && (in_control_reg[i*10 +: 10] == {cur_sl, cur_sp});
            if (hit) begin
                if (sb[i].size() < DEPTH) begin
                    sb[i].push_back(cur_pl);
                    any = 1'b1;
                end else begin
                    ovf_m[i] = 1'b1;
                end
            end
        end
        if (cur_vld && !any && dm < DMAX) dm++;
        @(posedge clk);
        #1;
        chk("drop_count", 64'(drop_count), 64'(dm));
        chk("overflow", 64'(overflow_flag), 64'(ovf_m));
    endtask

    task automatic send(input logic [5:0] sl, input logic [3:0] sp, input logic [63:0] pl);
        cur_vld = 1'b1; cur_sl = sl; cur_sp = sp; cur_pl = pl;
        stream_in = {1'b1, 6'h3f, 4'h9, sl, sp, pl};
        step();
    endtask

    task automatic idle(input int n);
        cur_vld = 1'b0;
        stream_in = '0;
        for (int k = 0; k < n; k++) step();
    endtask

    task automatic do_reset();
        reset = 1'b0;
        cur_vld = 1'b0;
        stream_in = '0;
        ack_user2b_in = '0;
        @(posedge clk);
        #1;
        reset = 1'b1;
        port_enable = '1;
        for (int i = 0; i < NP; i++) begin
            sb[i].delete();
            cons[i] = 0;
            pulse_cnt[i] = 0;
            set_ctrl(i, 6'(40 + i), 4'(i));
        end
        ovf_m = '0;
        dm = 0;
        chk("rst_vld", 64'(vld2user), 64'd0);
        chk("rst_dout", 64'(|dout2user), 64'd0);
        chk("rst_credit", 64'(freespace_update), 64'd0);
        chk("rst_ovf", 64'(overflow_flag), 64'd0);
        chk("rst_drop", 64'(drop_count), 64'd0);
    endtask

    initial begin
        reset = 1'b0;
        stream_in = '0;
        in_control_reg = '0;
        port_enable = '0;
        ack_user2b_in = '0;
        cur_vld = 1'b0; cur_sl = '0; cur_sp = '0; cur_pl = '0;
        @(posedge clk);
        do_reset();

        // In-order delivery with one-cycle latency; ack on empty is ignored.
        set_ctrl(0, 6'd2, 4'd1);
        send(6'd2, 4'd1, 64'hA0A0_0000_0000_0001);
        chk("t1_latency", 64'(vld2user[0]), 64'd1);
        send(6'd2, 4'd1, 64'hB0B0_0000_0000_0002);
        send(6'd2, 4'd1, 64'hC0C0_0000_0000_0003);
        idle(1);
        ack_user2b_in[0] = 1'b1;
        idle(3);
        chk("t1_empty", 64'(vld2user[0]), 64'd0);
        idle(1);
        chk("t1_ack_empty", 64'(vld2user[0]), 64'd0);

        // Credit pulses after the 4th and 8th pops.
        do_reset();
        set_ctrl(0, 6'd2, 4'd1);
        ack_user2b_in[0] = 1'b1;
        for (int k = 0; k < 8; k++) send(6'd2, 4'd1, 64'(100 + k));
        idle(4);
        chk("t2_pulses", 64'(pulse_cnt[0]), 64'd2);

        // Multicast to ports 1 and 3.
        do_reset();
        set_ctrl(1, 6'd5, 4'd0);
        set_ctrl(3, 6'd5, 4'd0);
        send(6'd5, 4'd0, 64'h1234_5678_9abc_def0);
        chk("t3_vld1", 64'(vld2user[1]), 64'd1);
        chk("t3_vld3", 64'(vld2user[3]), 64'd1);
        chk("t3_dout1", dout2user[1*PL +: PL], 64'h1234_5678_9abc_def0);
        chk("t3_dout3", dout2user[3*PL +: PL], 64'h1234_5678_9abc_def0);
        chk("t3_drop", 64'(drop_count), 64'd0);
        ack_user2b_in[1] = 1'b1;
        ack_user2b_in[3] = 1'b1;
        idle(2);

        // Overflow on a full FIFO, then push with simultaneous pop at full.
        do_reset();
        set_ctrl(0, 6'd2, 4'd1);
        for (int k = 0; k < 5; k++) send(6'd2, 4'd1, 64'(200 + k));
        chk("t4_ovf", 64'(overflow_flag[0]), 64'd1);
        chk("t4_drop", 64'(drop_count), 64'd1);
        ack_user2b_in[0] = 1'b1;
        send(6'd2, 4'd1, 64'd300);
        chk("t4_drop_full_pop", 64'(drop_count), 64'd1);
        idle(3);
        chk("t4_still_vld", 64'(vld2user[0]), 64'd1);
        idle(1);
        chk("t4_drained", 64'(vld2user[0]), 64'd0);

        // Disabled port drains queued words and still returns credit.
        do_reset();
        set_ctrl(2, 6'd7, 4'd3);
        for (int k = 0; k < 4; k++) send(6'd7, 4'd3, 64'(400 + k));
        port_enable[2] = 1'b0;
        send(6'd7, 4'd3, 64'd499);
        chk("t5_drop", 64'(drop_count), 64'd1);
        chk("t5_no_ovf", 64'(overflow_flag[2]), 64'd0);
        ack_user2b_in[2] = 1'b1;
        idle(6);
        chk("t5_pulse", 64'(pulse_cnt[2]), 64'd1);
        chk("t5_empty", 64'(vld2user[2]), 64'd0);

        // Drop counter saturation, then reset with everything active.
        do_reset();
        set_ctrl(0, 6'd2, 4'd1);
        for (int k = 0; k < 5; k++) send(6'd2, 4'd1, 64'(500 + k));
        for (int k = 0; k < 5; k++) send(6'd63, 4'd15, 64'(600 + k));
        chk("t6_sat", 64'(drop_count), 64'd3);
        ack_user2b_in[0] = 1'b1;
        for (int k = 0; k < 4; k++) send(6'd2, 4'd1, 64'(700 + k));
        chk("t6_credit_hi", 64'(freespace_update[0]), 64'd1);
        chk("t6_vld_hi", 64'(vld2user[0]), 64'd1);
        do_reset();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1);
    end

endmodule
